// File: rtl/trim_ovrd_ijtag_pkg.sv
// trim_ovrd_ijtag_pkg
//   Shared definitions for the trim/fuse-override IJTAG initiator:
//   - state_e                 : initiator FSM states (the VERIFY_* states are
//                               only reached when TRIM_OVRD_READBACK_CHECK_EN
//                               is defined)
//   - TRIM_OVRD_WIDTH_DEFAULT : default override TDR length (hdspsr TDR)
//   - cnt_width_t / cnt_width : width of the shift bit counter, $clog2(W+1)
package trim_ovrd_ijtag_pkg;

  localparam int unsigned TRIM_OVRD_WIDTH_DEFAULT = 20;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SHIFT,
    UPDATE,
    VERIFY_CAP,
    VERIFY_SHIFT,
    VERIFY_UPD,
    RESP
  } state_e;

  typedef int unsigned cnt_width_t;

  // The counter must be able to hold WIDTH without wrapping.
  function automatic cnt_width_t cnt_width(input cnt_width_t width);
    return cnt_width_t'($clog2(width + 1));
  endfunction

endpackage

// File: rtl/trim_ovrd_ijtag_shifter.sv
// trim_ovrd_ijtag_shifter
//   WIDTH-bit transmit/capture buffer for one IJTAG scan.
//   The transmit side rotates rather than shifts, so after WIDTH shift
//   cycles it holds the loaded word again and can be re-scanned.
//   The capture side shifts tdr_so in at the MSB, so after WIDTH samples
//   bit k holds the k-th bit seen.
// Ports:
//   clk, rst_n   : TDR clock, asynchronous active-low reset
//   load_en      : load load_data into the transmit buffer
//   load_data    : word to transmit
//   shift_en     : rotate the transmit buffer by one bit
//   sample_en    : shift so into the capture buffer
//   so           : serial data returned by the TDR
//   tx_bit_next  : bit to drive on the serial output in the next cycle
//   rx_data      : captured word
module trim_ovrd_ijtag_shifter
  import trim_ovrd_ijtag_pkg::*;
#(
  parameter int unsigned WIDTH = TRIM_OVRD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             sample_en,
  input  logic             so,
  output logic             tx_bit_next,
  output logic [WIDTH-1:0] rx_data
);

  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] tx_rot;
  logic [WIDTH-1:0] rx_shift;

  if (WIDTH > 1) begin : g_multi
    assign tx_rot   = {tx_q[0], tx_q[WIDTH-1:1]};
    assign rx_shift = {so, rx_q[WIDTH-1:1]};
  end else begin : g_single
    assign tx_rot   = tx_q;
    assign rx_shift = so;
  end

  always_comb begin
    tx_d = tx_q;
    rx_d = rx_q;
    if (load_en) begin
      tx_d = load_data;
    end else if (shift_en) begin
      tx_d = tx_rot;
    end
    if (sample_en) begin
      rx_d = rx_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

  // Look ahead one bit while shifting so the serial output can be registered.
  assign tx_bit_next = shift_en ? tx_rot[0] : tx_q[0];
  assign rx_data     = rx_q;

endmodule

// File: rtl/trim_ovrd_ijtag_initiator.sv
// trim_ovrd_ijtag_initiator
//   Runs one Capture-Shift-Update sequence on a WIDTH-bit IJTAG override TDR
//   per valid/ready request: writes req_data into the TDR update latches and
//   returns the word the TDR captured before the write.
//   Optional feature, macro TRIM_OVRD_READBACK_CHECK_EN: after the write the
//   TDR is captured and re-scanned with the same word, and any bit differing
//   from req_data sets rsp_mismatch. Without the macro rsp_mismatch is 0.
// Ports:
//   ijtag_tck, ijtag_reset      : TDR clock, asynchronous active-low reset
//   req_valid/req_ready/req_data: write request
//   rsp_valid/rsp_ready         : response handshake
//   rsp_data                    : pre-write TDR contents, bit k = k-th bit out
//   rsp_mismatch                : readback compare failed
//   busy                        : scan sequence in progress
//   tdr_sel/ce/se/ue/si         : registered IJTAG controls and serial data
//   tdr_so                      : serial data from the TDR
module trim_ovrd_ijtag_initiator
  import trim_ovrd_ijtag_pkg::*;
#(
  parameter int unsigned WIDTH = TRIM_OVRD_WIDTH_DEFAULT
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_mismatch,
  output logic             busy,
  output logic             tdr_sel,
  output logic             tdr_ce,
  output logic             tdr_se,
  output logic             tdr_ue,
  output logic             tdr_si,
  input  logic             tdr_so
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             tdr_sel_q, tdr_sel_d;
  logic             tdr_ce_q, tdr_ce_d;
  logic             tdr_se_q, tdr_se_d;
  logic             tdr_ue_q, tdr_ue_d;
  logic             tdr_si_q, tdr_si_d;
  logic             load_en;
  logic             shift_en;
  logic             sample_en;
  logic             tx_bit_next;

  trim_ovrd_ijtag_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .clk        (ijtag_tck),
    .rst_n      (ijtag_reset),
    .load_en    (load_en),
    .load_data  (req_data),
    .shift_en   (shift_en),
    .sample_en  (sample_en),
    .so         (tdr_so),
    .tx_bit_next(tx_bit_next),
    .rx_data    (rsp_data)
  );

  // Next state and buffer control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    sample_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          load_en = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        shift_en  = 1'b1;
        sample_en = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = UPDATE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UPDATE: begin
`ifdef TRIM_OVRD_READBACK_CHECK_EN
        state_d = VERIFY_CAP;
`else
        state_d = RESP;
`endif
      end
`ifdef TRIM_OVRD_READBACK_CHECK_EN
      VERIFY_CAP: begin
        state_d = VERIFY_SHIFT;
        cnt_d   = '0;
      end
      VERIFY_SHIFT: begin
        // Re-scan only; the first capture stays in the capture buffer.
        shift_en = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = VERIFY_UPD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      VERIFY_UPD: begin
        state_d = RESP;
      end
`endif
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output registers decoded from the next state
  always_comb begin
    req_ready_d = (state_d == IDLE);
    tdr_sel_d   = (state_d != IDLE) && (state_d != RESP);
    tdr_ce_d    = (state_d == CAPTURE) || (state_d == VERIFY_CAP);
    tdr_se_d    = (state_d == SHIFT) || (state_d == VERIFY_SHIFT);
    tdr_ue_d    = (state_d == UPDATE) || (state_d == VERIFY_UPD);
    tdr_si_d    = tdr_se_d & tx_bit_next;
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      tdr_sel_q   <= 1'b0;
      tdr_ce_q    <= 1'b0;
      tdr_se_q    <= 1'b0;
      tdr_ue_q    <= 1'b0;
      tdr_si_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      tdr_sel_q   <= tdr_sel_d;
      tdr_ce_q    <= tdr_ce_d;
      tdr_se_q    <= tdr_se_d;
      tdr_ue_q    <= tdr_ue_d;
      tdr_si_q    <= tdr_si_d;
    end
  end

`ifdef TRIM_OVRD_READBACK_CHECK_EN
  logic mism_q, mism_d;

  // In re-scan cycle k the registered serial output still holds req_data[k],
  // which is exactly the bit the TDR should return at the end of that cycle.
  always_comb begin
    mism_d = mism_q;
    if (load_en) begin
      mism_d = 1'b0;
    end else if ((state_q == VERIFY_SHIFT) && (tdr_so != tdr_si_q)) begin
      mism_d = 1'b1;
    end
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      mism_q <= 1'b0;
    end else begin
      mism_q <= mism_d;
    end
  end

  assign rsp_mismatch = mism_q;
`else
  assign rsp_mismatch = 1'b0;
`endif

  assign req_ready = req_ready_q;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE) && (state_q != RESP);
  assign tdr_sel   = tdr_sel_q;
  assign tdr_ce    = tdr_ce_q;
  assign tdr_se    = tdr_se_q;
  assign tdr_ue    = tdr_ue_q;
  assign tdr_si    = tdr_si_q;

endmodule

// File: tb/tb_trim_ovrd_ijtag_initiator.sv
module tb_trim_ovrd_ijtag_initiator;

  localparam int W = 20;
`ifdef TRIM_OVRD_READBACK_CHECK_EN
  localparam bit RBC = 1'b1;
`else
  localparam bit RBC = 1'b0;
`endif
  localparam int LAT    = RBC ? 2 * W + 5 : W + 3;
  localparam int SE_EXP = RBC ? 2 * W : W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         rsp_mismatch;
  logic         busy;
  logic         tdr_sel, tdr_ce, tdr_se, tdr_ue, tdr_si;
  logic         tdr_so;
  logic         so_stuck = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trim_ovrd_ijtag_initiator #(
    .WIDTH(W)
  ) dut (
    .ijtag_tck   (clk),
    .ijtag_reset (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_mismatch(rsp_mismatch),
    .busy        (busy),
    .tdr_sel     (tdr_sel),
    .tdr_ce      (tdr_ce),
    .tdr_se      (tdr_se),
    .tdr_ue      (tdr_ue),
    .tdr_si      (tdr_si),
    .tdr_so      (tdr_so)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural IJTAG TDR: capture/shift on posedge, so retimed and
  // update latches written on negedge, everything cleared by reset.
  logic [W-1:0] tdr_sr = '0;
  logic [W-1:0] tdr_upd = '0;
  logic         tdr_so_r = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) tdr_sr = '0;
    else if (tdr_sel && tdr_ce) tdr_sr = tdr_upd;
    else if (tdr_sel && tdr_se) tdr_sr = {tdr_si, tdr_sr[W-1:1]};
  end

  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      tdr_upd  = '0;
      tdr_so_r = 1'b0;
    end else begin
      tdr_so_r = tdr_sr[0];
      if (tdr_sel && tdr_ue) tdr_upd = tdr_sr;
    end
  end

  assign tdr_so = so_stuck ? 1'b1 : tdr_so_r;

  // Reference model: n = cycles since the accepting edge (0 = no request).
  int           n = 0;
  bit           alive = 1'b0;
  logic [W-1:0] word = '0;
  logic [W-1:0] tdr_word = '0;
  logic [W-1:0] exp_rsp = '0;
  logic         exp_mism = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      n        = 0;
      alive    = 1'b0;
      tdr_word = '0;
    end else if (n == 0) begin
      if (alive && req_valid) begin
        n        = 1;
        word     = req_data;
        exp_rsp  = so_stuck ? '1 : tdr_word;
        exp_mism = RBC && so_stuck && (req_data != '1);
        tdr_word = req_data;
      end
      alive = 1'b1;
    end else if (n == LAT) begin
      if (rsp_ready) n = 0;
    end else begin
      n = n + 1;
    end
  end

  // Per-cycle compare against the model.
  int se_cnt = 0;
  bit rv_prev = 1'b0;

  initial forever begin
    logic e_ce, e_se, e_ue, e_sel, e_si;
    int   idx;
    @(negedge clk);
    e_ce  = (n == 1) || (RBC && n == W + 3);
    e_se  = (n >= 2 && n <= W + 1) || (RBC && n >= W + 4 && n <= 2 * W + 3);
    e_ue  = (n == W + 2) || (RBC && n == 2 * W + 4);
    e_sel = (n >= 1) && (n <= LAT - 1);
    e_si  = 1'b0;
    if (e_se) begin
      idx  = (n <= W + 1) ? n - 2 : n - W - 4;
      e_si = word[idx];
    end
    chk("tdr_ce", 64'(tdr_ce), 64'(e_ce));
    chk("tdr_se", 64'(tdr_se), 64'(e_se));
    chk("tdr_ue", 64'(tdr_ue), 64'(e_ue));
    chk("tdr_sel", 64'(tdr_sel), 64'(e_sel));
    chk("tdr_si", 64'(tdr_si), 64'(e_si));
    chk("busy", 64'(busy), 64'(e_sel));
    chk("rsp_valid", 64'(rsp_valid), 64'(n == LAT));
    chk("req_ready", 64'(req_ready), 64'(alive && n == 0));
    if (n == LAT) begin
      chk("rsp_data", 64'(rsp_data), 64'(exp_rsp));
      chk("rsp_mismatch", 64'(rsp_mismatch), 64'(exp_mism));
    end
    chk("one_hot_ce_se_ue", 64'($countones({tdr_ce, tdr_se, tdr_ue}) <= 1), 64'd1);
    chk("sel_covers_en", 64'(!(tdr_ce || tdr_se || tdr_ue) || tdr_sel), 64'd1);
    if (n == 1) se_cnt = 0;
    if (tdr_se) se_cnt++;
    if (rsp_valid && !rv_prev) chk("se_cycles", 64'(se_cnt), 64'(SE_EXP));
    rv_prev = rsp_valid;
  end

  // One write; called at a negedge, returns at the negedge after acceptance
  // of the response. hold = extra response cycles with rsp_ready low.
  task automatic do_write(input logic [W-1:0] d, input int hold,
                          output logic [W-1:0] rd, output logic mm);
    int t;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_data  = d;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    t = 1;
    while (!rsp_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("latency", 64'(t), 64'(LAT));
    rd = rsp_data;
    mm = rsp_mismatch;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_data  = W'($urandom);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         mm;
    int           t;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'({req_ready, rsp_valid, rsp_mismatch, busy,
                           tdr_sel, tdr_ce, tdr_se, tdr_ue, tdr_si}), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    do_write(20'hA5A5A, 0, rd, mm);
    chk("first_capture", 64'(rd), 64'h00000);
    chk("first_mismatch", 64'(mm), 64'd0);
    chk("tdr_holds_a5a5a", 64'(tdr_upd), 64'hA5A5A);

    do_write(20'h0F0F0, 10, rd, mm);
    chk("second_capture", 64'(rd), 64'hA5A5A);
    chk("tdr_holds_0f0f0", 64'(tdr_upd), 64'h0F0F0);

    // Reset during shift cycle 7
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1;
    req_data  = 20'h5C3E1;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (n != 9 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("reach_shift7", 64'(n), 64'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 64'({req_ready, rsp_valid, rsp_mismatch, busy,
                                 tdr_sel, tdr_ce, tdr_se, tdr_ue, tdr_si}), 64'd0);
    chk("async_reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("async_reset_tdr", 64'(tdr_upd), 64'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    do_write(20'h3C3C3, 0, rd, mm);
    chk("after_reset_capture", 64'(rd), 64'h00000);

    so_stuck = 1'b1;
    do_write(20'h00001, 0, rd, mm);
    chk("stuck_capture", 64'(rd), 64'hFFFFF);
    chk("stuck_mismatch", 64'(mm), 64'(RBC));
    so_stuck = 1'b0;

    do_write(20'h12345, 0, rd, mm);
    chk("capture_after_stuck", 64'(rd), 64'h00001);

    // Random traffic with ignored requests, response back-pressure and one reset
    for (int c = 0; c < 1500; c++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_data  = W'($urandom);
      rsp_ready = ($urandom_range(0, 3) == 0);
      if (c == 700) #2 rst_n = 1'b0;
      if (c == 702) #2 rst_n = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    rsp_ready = 1'b0;
    chk("drained_idle", 64'({busy, rsp_valid}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
